// File: rtl/intr_trap_seq_if.sv
// ----------------------------------------------------------------------------
// intr_trap_seq_if
// Trap-entry handshake between intr_trap_seq (master) and the pipeline/CSR
// file (slave).
//   trap_valid  : trap-entry request, held until accepted
//   trap_ready  : pipeline accepts the redirect
//   trap_pc     : redirect target
//   trap_mepc   : value to write to mepc
//   trap_mcause : value to write to mcause
// ----------------------------------------------------------------------------
interface intr_trap_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            trap_valid;
    logic            trap_ready;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_mepc;
    logic [XLEN-1:0] trap_mcause;

    modport master (
        output trap_valid,
        output trap_pc,
        output trap_mepc,
        output trap_mcause,
        input  trap_ready
    );

    modport slave (
        input  trap_valid,
        input  trap_pc,
        input  trap_mepc,
        input  trap_mcause,
        output trap_ready
    );
endinterface

// File: rtl/intr_trap_seq.sv
// ----------------------------------------------------------------------------
// intr_trap_seq
// Core-side interrupt sequencer. Latches pending interrupt requests, applies
// mie / mstatus.MIE masking with fixed priority (external > software > timer),
// waits for an instruction boundary and then issues a trap-entry request over
// a valid/ready handshake. Acknowledges the serviced source and handles mret.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   intr_req[2:0]     level requests: [0] MSIP, [1] MTIP, [2] MEIP
//   mie_bits[2:0]     per-source enables
//   mstatus_mie       current global interrupt enable
//   mtvec             trap vector base, [1:0] = mode
//   retire_valid      instruction boundary this cycle
//   retire_next_pc    PC following the retiring instruction
//   mret_valid        an mret retires this cycle
//   trap              trap handshake (intr_trap_seq_if.master)
//   mstatus_mie_wr    one-cycle write strobe for mstatus MIE/MPIE
//   mstatus_mie_nxt   new MIE value
//   mstatus_mpie_nxt  new MPIE value
//   intr_ack[2:0]     one-hot, one-cycle acknowledge to the serviced source
//
// Build option: define MTVEC_VECTORED_EN to honour mtvec mode 1 (vectored);
// otherwise trap_pc is always the aligned mtvec base.
// ----------------------------------------------------------------------------
module intr_trap_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            intr_req,
    input  logic [2:0]            mie_bits,
    input  logic                  mstatus_mie,
    input  logic [XLEN-1:0]       mtvec,
    input  logic                  retire_valid,
    input  logic [XLEN-1:0]       retire_next_pc,
    input  logic                  mret_valid,
    intr_trap_seq_if.master       trap,
    output logic                  mstatus_mie_wr,
    output logic                  mstatus_mie_nxt,
    output logic                  mstatus_mpie_nxt,
    output logic [2:0]            intr_ack
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        TRAP_REQ = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      pending_q, pending_d;
    logic            mpie_q, mpie_d;
    logic [2:0]      cap_src_q, cap_src_d;
    logic            cap_mie_q, cap_mie_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [2:0]      ack_q, ack_d;
    logic            wr_q, wr_d;
    logic            mie_nxt_q, mie_nxt_d;
    logic            mpie_nxt_q, mpie_nxt_d;

    logic [2:0]      eligible;
    logic [2:0]      sel_src;
    logic [3:0]      sel_code;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_target;
    logic [XLEN-1:0] sel_cause;

    // The source being acknowledged this cycle is excluded so its stale
    // pending bit cannot restart the sequencer before it clears.
    assign eligible = pending_q & ~ack_q & mie_bits & {3{mstatus_mie}};

    always_comb begin
        sel_src  = '0;
        sel_code = 4'd0;
        if (eligible[2]) begin
            sel_src  = 3'b100;
            sel_code = 4'd11;
        end else if (eligible[0]) begin
            sel_src  = 3'b001;
            sel_code = 4'd3;
        end else if (eligible[1]) begin
            sel_src  = 3'b010;
            sel_code = 4'd7;
        end
    end

    assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef MTVEC_VECTORED_EN
    // Only mode 1 is vectored; reserved modes 2/3 fall back to direct.
    assign tvec_target = (mtvec[1:0] == 2'b01)
                       ? tvec_base + (XLEN'(sel_code) << 2)
                       : tvec_base;
`else
    logic unused_mode_bits;
    assign unused_mode_bits = ^mtvec[1:0];
    assign tvec_target      = tvec_base;
`endif

    always_comb begin
        sel_cause           = XLEN'(sel_code);
        sel_cause[XLEN-1]   = 1'b1;
    end

    // Pending: set by a high request, cleared by the acknowledge, and
    // otherwise follows a falling request unless that source is captured.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (ack_q[i]) begin
                pending_d[i] = 1'b0;
            end else if (intr_req[i]) begin
                pending_d[i] = 1'b1;
            end else if (!((state_q == TRAP_REQ) && cap_src_q[i])) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mpie_d     = mpie_q;
        cap_src_d  = cap_src_q;
        cap_mie_d  = cap_mie_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        mepc_d     = mepc_q;
        cause_d    = cause_q;
        ack_d      = '0;
        wr_d       = 1'b0;
        mie_nxt_d  = mie_nxt_q;
        mpie_nxt_d = mpie_nxt_q;

        unique case (state_q)
            IDLE: begin
                if (mret_valid) begin
                    wr_d       = 1'b1;
                    mie_nxt_d  = mpie_q;
                    mpie_nxt_d = 1'b1;
                    mpie_d     = 1'b1;
                end
                if (eligible != 3'b000) begin
                    state_d = WAIT_BND;
                end
            end

            WAIT_BND: begin
                if (mret_valid) begin
                    wr_d       = 1'b1;
                    mie_nxt_d  = mpie_q;
                    mpie_nxt_d = 1'b1;
                    mpie_d     = 1'b1;
                end
                if (eligible == 3'b000) begin
                    state_d = IDLE;
                end else if (retire_valid && !mret_valid) begin
                    // Capture everything now; trap_valid rises one cycle
                    // later with the outputs already stable.
                    cap_src_d = sel_src;
                    cap_mie_d = mstatus_mie;
                    pc_d      = tvec_target;
                    mepc_d    = retire_next_pc;
                    cause_d   = sel_cause;
                    state_d   = TRAP_REQ;
                end
            end

            TRAP_REQ: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (trap.trap_ready) begin
                    valid_d    = 1'b0;
                    ack_d      = cap_src_q;
                    wr_d       = 1'b1;
                    mie_nxt_d  = 1'b0;
                    mpie_nxt_d = cap_mie_q;
                    mpie_d     = cap_mie_q;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            mpie_q     <= 1'b1;
            cap_src_q  <= '0;
            cap_mie_q  <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            mepc_q     <= '0;
            cause_q    <= '0;
            ack_q      <= '0;
            wr_q       <= 1'b0;
            mie_nxt_q  <= 1'b0;
            mpie_nxt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mpie_q     <= mpie_d;
            cap_src_q  <= cap_src_d;
            cap_mie_q  <= cap_mie_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            mepc_q     <= mepc_d;
            cause_q    <= cause_d;
            ack_q      <= ack_d;
            wr_q       <= wr_d;
            mie_nxt_q  <= mie_nxt_d;
            mpie_nxt_q <= mpie_nxt_d;
        end
    end

    assign trap.trap_valid  = valid_q;
    assign trap.trap_pc     = pc_q;
    assign trap.trap_mepc   = mepc_q;
    assign trap.trap_mcause = cause_q;
    assign intr_ack         = ack_q;
    assign mstatus_mie_wr   = wr_q;
    assign mstatus_mie_nxt  = mie_nxt_q;
    assign mstatus_mpie_nxt = mpie_nxt_q;

endmodule
